// File: rtl/tetris_top.sv
// Tetris core: a 4x8 locked board plus one falling 2x2-box piece, with moves,
// gravity, locking, row clearing and game over. board_out is the composite image.
module tetris_top #(
  parameter int DROP_PERIOD = 2
) (
  input  logic        in_clk,
  input  logic        in_restart_n,
  input  logic [1:0]  in_move,
  output logic [31:0] board_out
);

  typedef enum logic [1:0] {SPAWN, FALL, CLEAR, OVER} state_e;

  localparam int CW = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;

  state_e          state_q, state_d;
  logic [31:0]     board_q, board_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      mask_q, mask_d;
  logic [1:0]      x_q, x_d;
  logic [2:0]      y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [3:0]      candMask, mvMask, newMask;
  logic [2:0]      candX, mvX;
  logic [3:0]      curY, dropY;

  // Coordinates are one bit wider than the registers so that off-board
  // candidates (x-1 from 0, x+1 from 2, y+1 from 6) are caught by the bound test.
  function automatic logic [31:0] cellsOf(input logic [3:0] m, input logic [2:0] cx,
                                          input logic [3:0] cy);
    logic [5:0] p;
    p = {cy, 2'b00} + {3'b000, cx};
    return ({31'b0, m[3]} << p) | ({31'b0, m[2]} << (p + 6'd1)) |
           ({31'b0, m[1]} << (p + 6'd4)) | ({31'b0, m[0]} << (p + 6'd5));
  endfunction

  function automatic logic fits(input logic [31:0] b, input logic [3:0] m,
                                input logic [2:0] cx, input logic [3:0] cy);
    return (cx <= 3'd2) && (cy <= 4'd6) && ((cellsOf(m, cx, cy) & b) == 32'b0);
  endfunction

  function automatic logic [3:0] spawnMask(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b1111;
      2'd1:    return 4'b1100;
      2'd2:    return 4'b1110;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [3:0] rotateCw(input logic [3:0] m);
    return {m[1], m[3], m[0], m[2]};
  endfunction

  // Walk rows top to bottom; each surviving row is pushed in at the bottom,
  // so kept rows stay in order and zeros remain above them.
  function automatic logic [31:0] clearRows(input logic [31:0] b);
    logic [31:0] rest, kept;
    rest = b;
    kept = 32'b0;
    for (int r = 0; r < 8; r++) begin
      if (rest[3:0] != 4'hF) kept = {rest[3:0], kept[31:4]};
      rest = rest >> 4;
    end
    return kept;
  endfunction

  always_ff @(posedge in_clk) begin
    if (!in_restart_n) begin
      state_q <= SPAWN;
      board_q <= 32'b0;
      idx_q   <= 2'd0;
      mask_q  <= 4'b0;
      x_q     <= 2'd1;
      y_q     <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    curY     = {1'b0, y_q};
    dropY    = curY + 4'd1;
    candMask = mask_q;
    candX    = {1'b0, x_q};
    mvMask   = mask_q;
    mvX      = {1'b0, x_q};
    newMask  = spawnMask(idx_q);

    case (state_q)
      SPAWN: begin
        mask_d  = newMask;
        x_d     = 2'd1;
        y_d     = 3'd0;
        cnt_d   = '0;
        state_d = fits(board_q, newMask, 3'd1, 4'd0) ? FALL : OVER;
      end
      FALL: begin
        case (in_move)
          2'b01:   candX    = {1'b0, x_q} - 3'd1;
          2'b10:   candX    = {1'b0, x_q} + 3'd1;
          2'b11:   candMask = rotateCw(mask_q);
          default: ;
        endcase
        if (fits(board_q, candMask, candX, curY)) begin
          mvMask = candMask;
          mvX    = candX;
        end
        mask_d = mvMask;
        x_d    = mvX[1:0];
        // Gravity acts on the post-move piece within the same edge.
        if (cnt_q == CW'(DROP_PERIOD - 1)) begin
          cnt_d = '0;
          if (fits(board_q, mvMask, mvX, dropY)) begin
            y_d = dropY[2:0];
          end else begin
            board_d = board_q | cellsOf(mvMask, mvX, curY);
            idx_d   = idx_q + 2'd1;
            state_d = CLEAR;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CLEAR: begin
        board_d = clearRows(board_q);
        state_d = SPAWN;
      end
      default: ;
    endcase
  end

  assign board_out = board_q |
                     ((state_q == FALL) ? cellsOf(mask_q, {1'b0, x_q}, {1'b0, y_q}) : 32'b0);

endmodule

// File: tb/tb_tetris_top.sv
// Bench for tetris_top: a grid-level game model checked against board_out every
// cycle, plus scripted literal checkpoints and randomized play.
module tb_tetris_top;

  localparam int DROP_PERIOD = 2;

  typedef enum {M_SPAWN, M_FALL, M_CLEAR, M_OVER} mode_t;

  logic        clk;
  logic        restartN;
  logic [1:0]  moveCmd;
  logic [31:0] boardOut;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  bit              grid [8][4];
  bit              newGrid [8][4];
  bit [1:0][1:0]   pc, np;
  int              px, py, nx, tick, pidx, dst;
  int              keptRows[$];
  mode_t           mode = M_OVER;
  logic [31:0]     frozen;
  int              guard;
  bit              rstBit;

  tetris_top #(.DROP_PERIOD(DROP_PERIOD)) dut (
    .in_clk      (clk),
    .in_restart_n(restartN),
    .in_move     (moveCmd),
    .board_out   (boardOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Piece shapes as 2x2 pictures, indexed [row][col].
  function automatic bit [1:0][1:0] pieceShape(int i);
    bit [1:0][1:0] p;
    p = '0;
    p[0][0] = 1'b1;
    if (i != 3) p[0][1] = 1'b1;
    if (i == 0 || i == 2) p[1][0] = 1'b1;
    if (i == 0) p[1][1] = 1'b1;
    return p;
  endfunction

  function automatic bit [1:0][1:0] rotateCw(bit [1:0][1:0] p);
    bit [1:0][1:0] q;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        q[r][c] = p[1-c][r];
    return q;
  endfunction

  function automatic bit fits(bit [1:0][1:0] p, int x, int y);
    if (x < 0 || x > 2 || y < 0 || y > 6) return 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        if (p[r][c] && grid[y+r][x+c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] modelImage();
    logic [31:0] img;
    img = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        if (grid[r][c]) img[r*4+c] = 1'b1;
    if (mode == M_FALL)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          if (pc[r][c]) img[(py+r)*4+px+c] = 1'b1;
    return img;
  endfunction

  // Reference game, advanced once per rising edge from the same inputs as the DUT.
  always @(posedge clk) begin
    if (!restartN) begin
      foreach (grid[r, c]) grid[r][c] = 1'b0;
      pidx = 0; px = 1; py = 0; tick = 0;
      mode = M_SPAWN;
    end else begin
      case (mode)
        M_SPAWN: begin
          pc = pieceShape(pidx);
          px = 1; py = 0; tick = 0;
          mode = fits(pc, 1, 0) ? M_FALL : M_OVER;
        end
        M_FALL: begin
          np = pc;
          nx = px;
          case (moveCmd)
            2'b01:   nx = px - 1;
            2'b10:   nx = px + 1;
            2'b11:   np = rotateCw(pc);
            default: ;
          endcase
          if (fits(np, nx, py)) begin
            pc = np;
            px = nx;
          end
          if (tick == DROP_PERIOD - 1) begin
            tick = 0;
            if (fits(pc, px, py + 1)) begin
              py = py + 1;
            end else begin
              for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                  if (pc[r][c]) grid[py+r][px+c] = 1'b1;
              pidx = (pidx + 1) % 4;
              mode = M_CLEAR;
            end
          end else begin
            tick = tick + 1;
          end
        end
        M_CLEAR: begin
          keptRows.delete();
          for (int r = 0; r < 8; r++)
            if (!(grid[r][0] && grid[r][1] && grid[r][2] && grid[r][3]))
              keptRows.push_back(r);
          foreach (newGrid[r, c]) newGrid[r][c] = 1'b0;
          dst = 7;
          for (int i = keptRows.size() - 1; i >= 0; i--) begin
            for (int c = 0; c < 4; c++) newGrid[dst][c] = grid[keptRows[i]][c];
            dst = dst - 1;
          end
          foreach (grid[r, c]) grid[r][c] = newGrid[r][c];
          mode = M_SPAWN;
        end
        default: ;
      endcase
    end
  end

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (checkEn) checkOutput("cycle", boardOut, modelImage());

  task automatic checkLiteral(string name, logic [31:0] exp);
    checkOutput({name, "-dut"}, boardOut, exp);
    checkOutput({name, "-model"}, modelImage(), exp);
  endtask

  task automatic applyStimulus(bit rstN, logic [1:0] mv, int n);
    repeat (n) begin
      restartN = rstN;
      moveCmd  = mv;
      @(negedge clk);
    end
  endtask

  initial begin
    restartN = 1'b0;
    moveCmd  = 2'b00;

    applyStimulus(0, 2'b00, 2);
    checkEn = 1;
    checkLiteral("reset", 32'h0000_0000);
    applyStimulus(1, 2'b00, 1);
    checkLiteral("spawn", 32'h0000_0066);
    applyStimulus(1, 2'b01, 1);
    checkLiteral("move-left", 32'h0000_0033);
    applyStimulus(1, 2'b01, 1);
    checkLiteral("left-blocked-drop", 32'h0000_0330);
    applyStimulus(1, 2'b00, 12);
    checkLiteral("square-locked", 32'h3300_0000);
    applyStimulus(1, 2'b00, 2);
    checkLiteral("bar-spawn", 32'h3300_0006);
    applyStimulus(1, 2'b10, 1);
    checkLiteral("bar-right", 32'h3300_000C);
    applyStimulus(1, 2'b00, 13);
    checkLiteral("bar-locked", 32'h3F00_0000);
    applyStimulus(1, 2'b00, 1);
    checkLiteral("row-cleared", 32'h3000_0000);
    applyStimulus(1, 2'b00, 1);
    checkLiteral("l-spawn", 32'h3000_0026);
    applyStimulus(1, 2'b11, 1);
    checkLiteral("l-rotate", 32'h3000_0046);

    applyStimulus(0, 2'b00, 1);
    checkLiteral("restart", 32'h0000_0000);
    applyStimulus(1, 2'b00, 1);
    checkLiteral("restart-spawn", 32'h0000_0066);

    // Without moves the pieces pile up in columns 1-2 until a spawn collides.
    guard = 0;
    while (mode != M_OVER && guard < 400) begin
      applyStimulus(1, 2'b00, 1);
      guard++;
    end
    checks++;
    if (mode != M_OVER) begin
      errors++;
      $display("[TB] FAIL gameover-timeout: got %0d cycles expected game over within 400", guard);
    end
    frozen = boardOut;
    checkOutput("over-image", frozen, modelImage());
    repeat (10) begin
      applyStimulus(1, 2'($urandom_range(0, 3)), 1);
      checkOutput("over-frozen", boardOut, frozen);
    end

    applyStimulus(0, 2'b00, 1);
    checkLiteral("post-over-restart", 32'h0000_0000);
    for (int i = 0; i < 600; i++) begin
      rstBit = ($urandom_range(0, 99) != 0);
      applyStimulus(rstBit, 2'($urandom_range(0, 3)), 1);
    end

    checkEn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tetris_top.md
# tetris_top

Top level of the Tetris chip. Holds a 4-column × 8-row playfield, spawns a fixed repeating sequence of 2×2-box pieces, and applies player moves and gravity. It also locks pieces, clears full rows and detects game over. The 32-bit output is the composite image (locked cells OR falling piece) and drives the display.

## Interface
- DROP_PERIOD, default 2: FALL-state clocks per gravity step; legal range ≥1.
- in_clk  input  1  single system clock; all state updates on the rising edge.
- in_restart_n  input  1  synchronous, active-low reset/restart.
- in_move  input  2  player command: 00 none, 01 left, 10 right, 11 rotate clockwise.
- board_out  output  32  bit index = row*4 + col; row 0 is top, col 0 is left; 1 = occupied.

## Operation
- State:
  - locked board[31:0]
  - piece index 0..3
  - piece mask[3:0]: bit3 TL, bit2 TR, bit1 BL, bit0 BR
  - box position x (0..2), y (0..6), the top-left of the 2×2 box
  - gravity counter
  - FSM state
- Piece sequence, repeating: 0 square 1111, 1 bar 1100, 2 L 1110, 3 single 1000.
- Mask-to-cell map: TL→(y,x), TR→(y,x+1), BL→(y+1,x), BR→(y+1,x+1).
- Legality rule: a candidate placement is legal iff 0≤x≤2, 0≤y≤6, and no mask cell overlaps a locked cell. Bounds use the whole box even when a row or column of the mask is empty.
- Rotation (clockwise): newTL=BL, newTR=TL, newBR=TR, newBL=BR.
- FSM states:
  - SPAWN:
    - Load the mask for the current index at x=1, y=0; clear the gravity counter.
    - If the spawn placement overlaps locked cells → OVER, piece not shown.
    - Otherwise → FALL.
  - FALL, evaluated every clock:
    - Move: shift or rotate the candidate. Apply it only if legal; otherwise ignore it silently.
    - Gravity:
      - If counter == DROP_PERIOD-1, attempt y+1 on the post-move piece and reset the counter; otherwise increment the counter.
      - If the drop is illegal, OR the post-move piece into the board, advance the piece index (mod 4) → CLEAR.
  - CLEAR:
    - Remove all full rows simultaneously in one clock.
    - Rows above shift down to fill; zeros enter at the top.
    - → SPAWN.
  - OVER:
    - board_out frozen at the locked board; in_move ignored.
    - Leave only by reset.
- board_out:
  - In FALL: locked board OR the active piece cells.
  - In SPAWN, CLEAR and OVER: locked board only.
- Reset (in_restart_n=0 at an edge), from any state including mid-fall:
  - Board cleared, piece index 0, x=1, y=0, counter 0, state SPAWN.
  - board_out = 0.

## Timing
- Reset is synchronous and takes effect at the next rising edge; no asynchronous path.
- First edge with in_restart_n=1 performs SPAWN; board_out = 0x00000066 after that edge.
- in_move is sampled on every FALL edge. It is level-sensitive: one move per clock while held.
- A move and a gravity step in the same edge both take effect in that edge, move first.
- Lock occurs on the gravity edge whose drop is illegal. CLEAR follows on the next edge, then SPAWN on the one after.
- Latency from lock to the new piece being visible: 2 clocks (CLEAR, SPAWN).
- board_out is combinational from registers; its value is stable one edge after each update.

## Test plan
- Reset:
  - Hold in_restart_n=0 for 2 clocks → board_out=0.
  - Release and clock once → 0x00000066.
- Move and bound, DROP_PERIOD=2, after spawn:
  - in_move=01 on the counter-0 edge → 0x00000033.
  - Hold 01 one more edge: left is blocked and gravity drops → 0x00000330.
- Line clear:
  - Square moved to x=0 and left to land → rows 6-7 cols 0-1 = 0x33000000.
  - Next bar at x=2 lands at y=6 → after CLEAR, board_out=0x30000000; piece index 2 then spawns.
- Rotate:
  - With the bar at spawn (1,0), board_out=0x00000006.
  - in_move=11 on a non-gravity edge → 0x00000044.
  - Rotate at x=2 with a locked cell overlapping is ignored.
- Game over:
  - No moves: pieces stack at col 1-2 until a spawn overlaps → state OVER.
  - board_out constant over 10 clocks with random in_move.
- Mid-game restart:
  - Assert in_restart_n=0 for one edge during FALL → board_out=0.
  - Next edge with 1 → 0x00000066, piece index 0.
